// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan decoder: active-low segment
// patterns (bit6=a .. bit0=g) and the frame assembly FSM states.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    StSync,
    StCollect,
    StEmit
  } state_e;

endpackage

// File: rtl/seven_seg_to_hex.sv
// Combinational decode of one active-low segment pattern into a hex nibble,
// flagging the all-off pattern as blank and anything unknown as an error.
module seven_seg_to_hex
  import seven_seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       blank,
  output logic       err
);

  always_comb begin
    nibble = 4'h0;
    blank  = 1'b0;
    err    = 1'b0;
    unique case (pattern)
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_A:     nibble = 4'hA;
      SEG_B:     nibble = 4'hB;
      SEG_C:     nibble = 4'hC;
      SEG_D:     nibble = 4'hD;
      SEG_E:     nibble = 4'hE;
      SEG_F:     nibble = 4'hF;
      SEG_BLANK: blank  = 1'b1;
      default:   err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Recovers a multi-digit hex value from a multiplexed seven-segment display
// bus: debounces each strobe, assembles digits in scan order, publishes frames.
module seven_seg_scan_decoder
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic [6:0]              seven_seg,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic [NUM_DIGITS-1:0]   digit_blank,
  output logic                    frame_valid,
  output logic                    frame_err
);

  localparam int unsigned CntW  = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned IdxW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned SampW = NUM_DIGITS + 7;

  localparam logic [CntW-1:0] CntMax  = CntW'(STABLE_CYCLES);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);

  logic [SampW-1:0]      samp_d, samp_q;
  logic [CntW-1:0]       cnt_q;
  logic                  captured_q;
  logic [NUM_DIGITS-1:0] strobe;
  logic                  strobe_ok;
  logic [IdxW-1:0]       cap_idx;
  logic                  capture;
  logic [3:0]            cap_nib;
  logic                  cap_blank;
  logic                  cap_err;

  state_e                  state_q;
  logic [IdxW-1:0]         exp_q;
  logic                    store;
  logic                    publish;
  logic [4*NUM_DIGITS-1:0] stage_val_d, stage_val_q;
  logic [NUM_DIGITS-1:0]   stage_err_d, stage_err_q;
  logic [NUM_DIGITS-1:0]   stage_blank_d, stage_blank_q;
  logic [4*NUM_DIGITS-1:0] value_q;
  logic [NUM_DIGITS-1:0]   digit_err_q, digit_blank_q;
  logic                    frame_valid_q, frame_err_q;

  assign samp_d = {an, seven_seg};

  // A strobe counts only when exactly one an bit is low.
  assign strobe    = ~samp_q[SampW-1:7];
  assign strobe_ok = (strobe != '0) && ((strobe & (strobe - NUM_DIGITS'(1))) == '0);

  always_comb begin
    cap_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (strobe[i]) cap_idx = IdxW'(i);
    end
  end

  assign capture = (cnt_q == CntMax) && strobe_ok && !captured_q;

  seven_seg_to_hex u_dec (
    .pattern (samp_q[6:0]),
    .nibble  (cap_nib),
    .blank   (cap_blank),
    .err     (cap_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_q     <= '1;
      cnt_q      <= '0;
      captured_q <= 1'b0;
    end else begin
      samp_q <= samp_d;
      if (samp_d != samp_q) begin
        cnt_q      <= CntW'(1);
        captured_q <= 1'b0;
      end else begin
        if (cnt_q != CntMax) cnt_q <= cnt_q + CntW'(1);
        if (capture) captured_q <= 1'b1;
      end
    end
  end

  always_comb begin
    unique case (state_q)
      StSync:    store = capture && (cap_idx == '0);
      StCollect: store = capture && (cap_idx == exp_q);
      default:   store = 1'b0;
    endcase
    publish = store && (cap_idx == LastIdx);

    stage_val_d   = stage_val_q;
    stage_err_d   = stage_err_q;
    stage_blank_d = stage_blank_q;
    if (store) begin
      stage_val_d[{cap_idx, 2'b00} +: 4] = cap_nib;
      stage_err_d[cap_idx]               = cap_err;
      stage_blank_d[cap_idx]             = cap_blank;
    end
  end

  // Outputs load on the edge entering EMIT, with the last digit merged in,
  // so value and frame_valid change in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StSync;
      exp_q         <= '0;
      stage_val_q   <= '0;
      stage_err_q   <= '0;
      stage_blank_q <= '0;
      value_q       <= '0;
      digit_err_q   <= '0;
      digit_blank_q <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      stage_val_q   <= stage_val_d;
      stage_err_q   <= stage_err_d;
      stage_blank_q <= stage_blank_d;
      if (publish) begin
        value_q       <= stage_val_d;
        digit_err_q   <= stage_err_d;
        digit_blank_q <= stage_blank_d;
        frame_valid_q <= 1'b1;
      end
      unique case (state_q)
        StSync: begin
          if (store) begin
            exp_q   <= cap_idx + IdxW'(1);
            state_q <= publish ? StEmit : StCollect;
          end
        end
        StCollect: begin
          if (store) begin
            exp_q <= exp_q + IdxW'(1);
            if (publish) state_q <= StEmit;
          end else if (capture) begin
            state_q     <= StSync;
            exp_q       <= '0;
            frame_err_q <= 1'b1;
          end
        end
        StEmit: begin
          state_q <= StSync;
          exp_q   <= '0;
        end
        default: begin
          state_q <= StSync;
          exp_q   <= '0;
        end
      endcase
    end
  end

  assign value       = value_q;
  assign digit_err   = digit_err_q;
  assign digit_blank = digit_blank_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Scoreboard bench: stimulus queues expected frame/abandon pulses with their
// cycle; a negedge monitor pops and compares whenever a pulse appears.
module tb_seven_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  an = 4'hF;
  logic [6:0]  seven_seg = 7'h7F;
  logic [15:0] value;
  logic [3:0]  digit_err;
  logic [3:0]  digit_blank;
  logic        frame_valid;
  logic        frame_err;

  localparam logic [6:0] PAT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  typedef struct {
    bit          is_err;
    logic [15:0] val;
    logic [3:0]  err;
    logic [3:0]  blank;
    int unsigned at;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] model_val = '0;
  logic [3:0]  model_err = '0;
  logic [3:0]  model_blank = '0;

  seven_seg_scan_decoder #(
    .NUM_DIGITS    (4),
    .STABLE_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .an          (an),
    .seven_seg   (seven_seg),
    .value       (value),
    .digit_err   (digit_err),
    .digit_blank (digit_blank),
    .frame_valid (frame_valid),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Inputs change at posedge+1; a stable digit is captured 5 edges later.
  task automatic drive_raw(input logic [3:0] a, input logic [6:0] s, input int n);
    an        = a;
    seven_seg = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic [6:0] s, input int n);
    logic [3:0] a;
    a = ~(4'b0001 << d);
    drive_raw(a, s, n);
  endtask

  task automatic push_frame(input logic [15:0] v, input logic [3:0] e, input logic [3:0] b);
    sb.push_back('{1'b0, v, e, b, cyc + 5});
    model_val   = v;
    model_err   = e;
    model_blank = b;
  endtask

  task automatic scan(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                      input logic [6:0] s3, input logic [15:0] v, input logic [3:0] e,
                      input logic [3:0] b);
    drive(0, s0, 8);
    drive(1, s1, 8);
    drive(2, s2, 8);
    push_frame(v, e, b);
    drive(3, s3, 8);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_value"}, {16'h0, value}, 32'h0);
    check({tag, "_digit_err"}, {28'h0, digit_err}, 32'h0);
    check({tag, "_digit_blank"}, {28'h0, digit_blank}, 32'h0);
    check({tag, "_frame_valid"}, {31'h0, frame_valid}, 32'h0);
    check({tag, "_frame_err"}, {31'h0, frame_err}, 32'h0);
  endtask

  always @(negedge clk) begin
    if (frame_valid || frame_err) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: frame_valid=%0b frame_err=%0b at cycle %0d, none expected",
                 frame_valid, frame_err, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("pulse_valid", {31'h0, frame_valid}, {31'h0, !mon_e.is_err});
        check("pulse_err", {31'h0, frame_err}, {31'h0, mon_e.is_err});
        check("pulse_cycle", cyc, mon_e.at);
        check("value", {16'h0, value}, {16'h0, mon_e.val});
        check("digit_err", {28'h0, digit_err}, {28'h0, mon_e.err});
        check("digit_blank", {28'h0, digit_blank}, {28'h0, mon_e.blank});
      end
    end else if (sb.size() != 0 && cyc > sb[0].at) begin
      n_checks++;
      n_fail++;
      $display("FAIL missing_pulse: no pulse by cycle %0d, expected at cycle %0d", cyc, sb[0].at);
      void'(sb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst = 1'b0;

    scan(PAT[1], PAT[2], PAT[3], PAT[4], 16'h4321, 4'b0000, 4'b0000);
    scan(PAT[1], PAT[2], 7'b1111110, 7'b1111111, 16'h0021, 4'b0100, 4'b1000);

    // Digit 1 too short: digit 2 is captured out of order and the frame is abandoned.
    drive(0, PAT[9], 8);
    drive(1, PAT[5], 3);
    sb.push_back('{1'b1, model_val, model_err, model_blank, cyc + 5});
    drive(2, PAT[6], 8);

    // Segment g toggles on hold cycle 3: only the new pattern (0) is captured.
    drive(0, PAT[8], 2);
    drive(0, PAT[0], 4);
    drive(1, PAT[9], 8);
    drive(2, PAT[10], 8);
    push_frame(16'hBA90, 4'b0000, 4'b0000);
    drive(3, PAT[11], 8);

    // Multi-cold strobe mid-frame is ignored.
    drive(0, PAT[12], 8);
    drive(1, PAT[13], 8);
    drive_raw(4'b0011, PAT[14], 10);
    drive(2, PAT[14], 8);
    push_frame(16'hFEDC, 4'b0000, 4'b0000);
    drive(3, PAT[15], 8);

    // Reset after digit 1 is captured.
    drive(0, PAT[5], 8);
    drive(1, PAT[6], 8);
    #3;
    rst = 1'b1;
    #1;
    check_zero_outputs("async_reset");
    model_val   = '0;
    model_err   = '0;
    model_blank = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    scan(PAT[5], PAT[6], PAT[7], PAT[8], 16'h8765, 4'b0000, 4'b0000);

    repeat (10) @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 32'h0);
    check("value_held", {16'h0, value}, 32'h8765);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_decoder.md
SEVEN_SEG_SCAN_DECODER -- requirements
Module: seven_seg_scan_decoder

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, the number of multiplexed display digits.
REQ-002 SHALL have parameter STABLE_CYCLES, default 4, the consecutive identical samples required before a digit is captured.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock; all inputs are synchronous to it.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 an  input  NUM_DIGITS  active-low digit strobe; an[i]=0 selects digit i.
REQ-007 seven_seg  input  7  active-low segments; bit6=a through bit0=g.
REQ-008 value  output  4*NUM_DIGITS  decoded frame; digit i maps to value[4i+3:4i].
REQ-009 digit_err  output  NUM_DIGITS  bit i set means digit i held an unrecognised pattern.
REQ-010 digit_blank  output  NUM_DIGITS  bit i set means digit i was blank (7'b1111111).
REQ-011 frame_valid  output  1  one-cycle pulse when a new value is published.
REQ-012 frame_err  output  1  one-cycle pulse when a frame is abandoned.

Function
REQ-013 Pattern table SHALL be, for 0..F: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100, 0001000, 1100000, 0110001, 1000010, 0110000, 0111000.
REQ-014 Pattern decoding SHALL give:
- table hit: that nibble, no flags;
- 7'b1111111: nibble 0, blank;
- any other pattern: nibble 0, err.
REQ-015 A strobe SHALL be valid only when an is one-cold; all-high or multi-cold an is "no strobe".
REQ-016 Each cycle the {an, seven_seg} sample SHALL be registered and compared with the previous cycle's sample.
- Any difference resets the stability counter to 1 and clears the episode-captured flag.
REQ-017 A capture SHALL occur in the cycle the counter reaches STABLE_CYCLES with a valid strobe and the flag clear; it sets the flag, giving at most one capture per episode.
REQ-018 The FSM SHALL have states SYNC, COLLECT and EMIT, and reset to SYNC with the expected index at 0.
- SYNC: a capture of digit 0 stores it, sets expected=1 and enters COLLECT (EMIT directly if NUM_DIGITS=1); captures of other digits are ignored.
- COLLECT: a capture of the expected digit stores it and increments the index; the last digit enters EMIT.
- COLLECT: a capture of any other digit enters SYNC and pulses frame_err the next cycle; value is unchanged.
- EMIT (one cycle): copy the staged nibbles and flags to the outputs, pulse frame_valid, return to SYNC with expected=0.
REQ-019 frame_valid SHALL be high exactly one cycle, the cycle after the last digit's capture.
REQ-020 value, digit_err and digit_blank SHALL change only on that cycle and hold between frames.
REQ-021 A "no strobe" sample SHALL neither capture nor abandon the frame.
REQ-022 Counter width SHALL be $clog2(STABLE_CYCLES+1) and saturate at STABLE_CYCLES.

Reset
REQ-023 Reset SHALL take effect asynchronously at any time, including mid-frame.
- Outputs go to 0: value, digit_err, digit_blank, frame_valid, frame_err.
- Internal state: staging registers 0, counter 0, flag clear, sample registers all-ones, FSM SYNC.
REQ-024 After rst deasserts, the first capture SHALL need STABLE_CYCLES fresh samples.

Structure
REQ-025 Package seven_seg_pkg SHALL hold:
- the 16 pattern constants and SEG_BLANK;
- the FSM state enum.
REQ-026 The combinational sub-module seven_seg_to_hex SHALL map pattern to nibble, blank and err, using only the package constants.
REQ-027 The top SHALL hold the sample registers, stability counter, FSM and staging/output registers.

Verification (NUM_DIGITS=4, STABLE_CYCLES=4)
REQ-028 Strobe digits 0..3 with patterns for 1,2,3,4, each held 8 cycles -> one frame_valid pulse; value=16'h4321, digit_err=0, digit_blank=0.
REQ-029 Same scan with digit 2=7'b1111110 and digit 3=7'b1111111 -> value=16'h0021, digit_err=4'b0100, digit_blank=4'b1000.
REQ-030 Hold digit 1 only 3 cycles, then strobe digit 2 for 8 cycles -> no capture of digit 1, frame_err pulse, no frame_valid, value unchanged.
REQ-031 Toggle a segment on hold cycle 3 of digit 0, then hold the new pattern 4 cycles -> a single capture of the new pattern, 4 cycles after the toggle.
REQ-032 Assert rst after digit 1 is captured, release, then run a full scan of 5,6,7,8 -> outputs 0 during reset; then value=16'h8765 with exactly one frame_valid.
REQ-033 Drive an=4'b0011 for 10 cycles mid-frame, then continue the scan -> ignored, frame completes normally.
